// File: rtl/adder_pkg.sv
// Shared definitions for cla_serial_word_adder: nibble width, FSM state encoding
// and the nibble-count helper used to size the sequencer.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } add_state_t;

    function automatic int nib_cnt(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla_nibble_slice.sv
// Purely combinational 4-bit carry-look-ahead adder slice; also exposes the carry
// into bit 3 so the parent can derive signed overflow from the top nibble.
module cla_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products over g/p/ci, so no carry ripples.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_serial_word_adder.sv
// Wide-word adder that streams operands LSB nibble first through one CLA slice,
// chaining the carry in a register. Define CLA_SIGNED_OVF_EN to add the ovf output.
module cla_serial_word_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = nib_cnt(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("cla_serial_word_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    add_state_t       state_q;
    logic [IDX_W-1:0] nib_idx_q;
    logic [IDX_W-1:0] nib_idx_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [IDX_W+1:0] bit_ofs;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             nib_c3;

    assign bit_ofs   = {nib_idx_q, 2'b00};
    assign nib_a     = a_q[bit_ofs +: NIBBLE_W];
    assign nib_b     = b_q[bit_ofs +: NIBBLE_W];
    assign nib_idx_d = nib_idx_q + 1'b1;

    cla_nibble_slice u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

`ifdef CLA_SIGNED_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;
`else
    logic unused_c3;
    assign unused_c3 = nib_c3;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            nib_idx_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CLA_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        nib_idx_q  <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[bit_ofs +: NIBBLE_W] <= nib_s;
                    carry_q   <= nib_co;
                    nib_idx_q <= nib_idx_d;
                    if (nib_idx_q == LAST_IDX) begin
                        cout_q      <= nib_co;
`ifdef CLA_SIGNED_OVF_EN
                        ovf_q       <= nib_c3 ^ nib_co;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_serial_word_adder.sv
// Scoreboard bench for cla_serial_word_adder: directed 16-bit cases plus random
// back-to-back traffic on a 16-bit and a 32-bit instance.
module tb_cla_serial_word_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 16-bit instance
    logic        iv0 = 1'b0, ir0, ci0 = 1'b0, ov0, or0 = 1'b1, co0, ovf0;
    logic [15:0] a0 = '0, b0 = '0, s0;
    // 32-bit instance
    logic        iv1 = 1'b0, ir1, ci1 = 1'b0, ov1, or1 = 1'b1, co1, ovf1;
    logic [31:0] a1 = '0, b1 = '0, s1;

    logic [63:0] exp0_q[$];
    logic [63:0] exp1_q[$];
    bit          eovf0_q[$];
    bit          eovf1_q[$];

    cla_serial_word_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(ci0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0)
`ifdef CLA_SIGNED_OVF_EN
        , .ovf(ovf0)
`endif
    );

    cla_serial_word_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(ci1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
`ifdef CLA_SIGNED_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef CLA_SIGNED_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: exact integer sum and signed-range overflow test.
    function automatic logic [63:0] add_model(input logic [63:0] x, input logic [63:0] y, input bit c);
        return x + y + 64'(c);
    endfunction

    function automatic bit ovf_model(input logic [63:0] x, input logic [63:0] y, input bit c, input int w);
        longint sx, sy, r, lim;
        sx  = longint'(x);
        sy  = longint'(y);
        lim = longint'(1) <<< (w - 1);
        if (sx >= lim) sx = sx - (lim * 2);
        if (sy >= lim) sy = sy - (lim * 2);
        r = sx + sy + longint'(c);
        return (r >= lim) || (r < -lim);
    endfunction

    // Monitors: pop the scoreboard whenever a result beat is about to complete.
    always @(negedge clk) begin
        if (rst_n && ov0 && or0) begin
            if (exp0_q.size() == 0) fail_now("w16 unexpected result beat");
            else begin
                check("w16 {cout,sum}", {47'd0, co0, s0}, exp0_q.pop_front());
`ifdef CLA_SIGNED_OVF_EN
                check("w16 ovf", 64'(ovf0), 64'(eovf0_q.pop_front()));
`else
                void'(eovf0_q.pop_front());
`endif
            end
        end
        if (rst_n && ov1 && or1) begin
            if (exp1_q.size() == 0) fail_now("w32 unexpected result beat");
            else begin
                check("w32 {cout,sum}", {31'd0, co1, s1}, exp1_q.pop_front());
`ifdef CLA_SIGNED_OVF_EN
                check("w32 ovf", 64'(ovf1), 64'(eovf1_q.pop_front()));
`else
                void'(eovf1_q.pop_front());
`endif
            end
        end
    end

    // Returns at posedge+1 right after the accept edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit c);
        bit ok = 1'b0;
        @(posedge clk); #1;
        iv0 = 1'b1; a0 = a; b0 = b; ci0 = c;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ir0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            exp0_q.push_back(add_model(64'(a), 64'(b), c));
            eovf0_q.push_back(ovf_model(64'(a), 64'(b), c, 16));
        end else fail_now("w16 accept timeout");
        @(posedge clk); #1;
        iv0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input bit c);
        bit ok = 1'b0;
        @(posedge clk); #1;
        iv1 = 1'b1; a1 = a; b1 = b; ci1 = c;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ir1) begin ok = 1'b1; break; end
        end
        if (ok) begin
            exp1_q.push_back(add_model(64'(a), 64'(b), c));
            eovf1_q.push_back(ovf_model(64'(a), 64'(b), c, 32));
        end else fail_now("w32 accept timeout");
        @(posedge clk); #1;
        iv1 = 1'b0; a1 = $urandom; b1 = $urandom;
    endtask

    task automatic wait_drained(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp0_q.size() == 0 && exp1_q.size() == 0 && !ov0 && !ov1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now(name);
    endtask

    initial begin
        int         cyc;
        logic [15:0] held_s;
        logic        held_c;
        bit          done16 = 1'b0;
        bit          done32 = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(ir0), 64'd1);
        check("reset out_valid", 64'(ov0), 64'd0);
        check("reset sum", 64'(s0), 64'd0);
        check("reset cout", 64'(co0), 64'd0);
        check("reset ovf", 64'(ovf0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned wrap and latency
        send16(16'hFFFF, 16'h0001, 1'b0);
        cyc = 0;
        for (int t = 1; t <= 10; t++) begin
            @(posedge clk); #1;
            if (ov0) begin cyc = t; break; end
        end
        check("w16 latency", 64'(cyc), 64'd4);
        wait_drained("wrap drain timeout");

        // Carry-in only, then signed overflow pattern
        send16(16'h1234, 16'h4321, 1'b1);
        wait_drained("cin drain timeout");
        send16(16'h7FFF, 16'h0001, 1'b0);
        wait_drained("ovf drain timeout");

        // Backpressure
        or0 = 1'b0;
        send16(16'hA5C3, 16'h6E19, 1'b1);
        check("sum cleared at accept", 64'(s0), 64'd0);
        cyc = 0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (ov0) begin cyc = t; break; end
        end
        if (cyc == 0) fail_now("backpressure out_valid timeout");
        held_s = s0;
        held_c = co0;
        check("held sum value", {47'd0, held_c, held_s}, add_model(64'h0000_0000_0000_A5C3, 64'h0000_0000_0000_6E19, 1'b1));
        for (int k = 0; k < 10; k++) begin
            iv0 = k[0]; a0 = 16'($urandom); b0 = 16'($urandom); ci0 = 1'($urandom);
            @(posedge clk); #1;
            check("bp sum stable", 64'(s0), 64'(held_s));
            check("bp cout stable", 64'(co0), 64'(held_c));
            check("bp in_ready low", 64'(ir0), 64'd0);
            check("bp out_valid held", 64'(ov0), 64'd1);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk); #1;
        check("after beat out_valid", 64'(ov0), 64'd0);
        check("after beat in_ready", 64'(ir0), 64'd1);
        check("bp scoreboard empty", 64'(exp0_q.size()), 64'd0);

        // Reset mid-RUN
        send16(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mid-run reset out_valid", 64'(ov0), 64'd0);
        check("mid-run reset sum", 64'(s0), 64'd0);
        check("mid-run reset in_ready", 64'(ir0), 64'd1);
        void'(exp0_q.pop_back());
        void'(eovf0_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        send16(16'h00FF, 16'h0F01, 1'b0);
        wait_drained("post-reset drain timeout");

        // Random back-to-back traffic on both widths
        fork
            begin
                for (int i = 0; i < 200; i++) send16(16'($urandom), 16'($urandom), 1'($urandom));
                done16 = 1'b1;
            end
            begin
                for (int i = 0; i < 200; i++) send32($urandom, $urandom, 1'($urandom));
                done32 = 1'b1;
            end
            begin
                while (!(done16 && done32)) begin
                    @(posedge clk); #1;
                    or0 = 1'($urandom);
                    or1 = 1'($urandom);
                end
                or0 = 1'b1;
                or1 = 1'b1;
            end
        join
        wait_drained("random drain timeout");
        check("w16 scoreboard drained", 64'(exp0_q.size()), 64'd0);
        check("w32 scoreboard drained", 64'(exp1_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
